csr_uart_fifo: RTL



---
 rtl/csr_uart_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 40 ++++
 rtl/csr_uart_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/csr_uart_pkg.sv
// csr_uart_pkg: CSR offsets, modify encodings, register bit positions and UART FSM states
package csr_uart_pkg;
  localparam logic [11:0] OFF_DATA = 12'd0;
  localparam logic [11:0] OFF_STATUS = 12'd1;
  localparam logic [11:0] OFF_DIV = 12'd2;
  localparam logic [1:0] MOD_NONE = 2'd0;
  localparam logic [1:0] MOD_WRITE = 2'd1;
  localparam logic [1:0] MOD_SET = 2'd2;
  localparam logic [1:0] MOD_CLEAR = 2'd3;
  localparam int ST_RX_OVF = 16;
  localparam int ST_TX_OVF = 17;
  localparam int ST_FRAME = 18;
  localparam int ST_IRQ_EN = 24;
  localparam int DATA_RX_EMPTY = 8;
  localparam int DATA_TX_FULL = 9;
  localparam logic [15:0] DIV_MIN = 16'd4;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;
  function automatic logic [15:0] csr_op(input logic [15:0] old, input logic [1:0] op, input logic [15:0] wd);
    return op == MOD_WRITE ? wd : op == MOD_SET ? old | wd : op == MOD_CLEAR ? old & ~wd : old;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead FIFO; ports push/pop/din in, dout/empty/full/count out
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign count = count_q;
  assign dout = mem_q[rp_q];
  assign do_pop = pop & ~empty;
  // a push into a full FIFO still lands when the same edge frees a slot
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + AW'(1) : wp_q;
      rp_q <= do_pop ? rp_q + AW'(1) : rp_q;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo: CSR-mapped 8N1 UART with TX/RX FIFOs; ports CSR read/modify/wdata/addr -> rdata/valid, serial rx/tx, irq_rx
module csr_uart_fifo import csr_uart_pkg::*; #(
  parameter logic [11:0] CSR_BASE = 12'hBC0,
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        irq_rx
);
  localparam int TXW = $clog2(TX_DEPTH) + 1;
  localparam int RXW = $clog2(RX_DEPTH) + 1;
  localparam logic [15:0] RST_DIV = 16'(CLOCK_RATE / BAUD_RATE);
  logic [11:0] off;
  logic [1:0] op;
  logic hit, sel_data, sel_status, sel_div;
  logic tx_push, tx_pop, tx_empty, tx_full, tx_end;
  logic rx_push, rx_pop, rx_empty, rx_full, rx_end, rx_ferr;
  logic [7:0] tx_dout, rx_dout;
  logic [TXW-1:0] tx_count;
  logic [RXW-1:0] rx_count;
  logic rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, ferr_q, ferr_d, irq_en_q, irq_en_d, irq_q;
  logic [15:0] div_q, div_d, eff_div, en_t;
  logic [2:0] w1c;
  uart_st_e tx_st_q, rx_st_q;
  logic [15:0] tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
  logic [2:0] tx_bit_q, rx_bit_q;
  logic [7:0] tx_sh_q, rx_sh_q;
  logic tx_q, s1_q, s2_q, prev_q;
  logic unused;
  assign unused = ^{wdata[31:25], wdata[23:19], modify[2]};
  // wrapping subtraction keeps the decode correct even for a base near 12'hFFF
  assign off = addr - CSR_BASE;
  assign op = modify[1:0];
  assign hit = off < 12'd3;
  assign sel_data = hit & (off == OFF_DATA);
  assign sel_status = hit & (off == OFF_STATUS);
  assign sel_div = hit & (off == OFF_DIV);
  assign valid = hit & (read | (op != MOD_NONE));
  assign tx_push = sel_data & (op != MOD_NONE);
  assign rx_pop = sel_data & read & ~rx_empty;
  assign eff_div = div_q < DIV_MIN ? DIV_MIN : div_q;
  assign tx = tx_q;
  assign irq_rx = irq_q;
  always_comb begin
    rdata = !hit ? 32'h0 :
            sel_data ? {22'h0, tx_full, rx_empty, rx_empty ? 8'h0 : rx_dout} :
            sel_status ? {7'h0, irq_en_q, 5'h0, ferr_q, tx_ovf_q, rx_ovf_q, 8'(tx_count), 8'(rx_count)} :
            {16'h0, div_q};
  end
  always_comb begin
    w1c = (sel_status && (op == MOD_WRITE || op == MOD_SET)) ? wdata[ST_FRAME:ST_RX_OVF] : 3'b0;
    rx_ovf_d = (rx_ovf_q & ~w1c[0]) | (rx_push & rx_full & ~rx_pop);
    tx_ovf_d = (tx_ovf_q & ~w1c[1]) | (tx_push & tx_full & ~tx_pop);
    ferr_d = (ferr_q & ~w1c[2]) | rx_ferr;
    en_t = csr_op(16'(irq_en_q), op, 16'(wdata[ST_IRQ_EN]));
    irq_en_d = sel_status ? en_t[0] : irq_en_q;
    div_d = sel_div ? csr_op(div_q, op, wdata[15:0]) : div_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      div_q <= RST_DIV;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      ferr_q <= ferr_d;
      irq_en_q <= irq_en_d;
      irq_q <= irq_en_q & ~rx_empty;
      div_q <= div_d;
    end
  end
  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );
  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );
  assign tx_end = tx_cnt_q == tx_div_q - 16'd1;
  // a frame starts from IDLE, or straight from the end of STOP for back-to-back bytes
  assign tx_pop = ~tx_empty & (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_end));
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q <= S_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_q <= 1'b1;
    end else if (tx_pop) begin
      tx_st_q <= S_START;
      tx_cnt_q <= '0;
      tx_div_q <= eff_div;
      tx_sh_q <= tx_dout;
      tx_q <= 1'b0;
    end else if (tx_st_q != S_IDLE) begin
      tx_cnt_q <= tx_end ? '0 : tx_cnt_q + 16'd1;
      if (tx_end)
        case (tx_st_q)
          S_START: begin
            tx_st_q <= S_DATA;
            tx_q <= tx_sh_q[0];
            tx_bit_q <= '0;
          end
          S_DATA: begin
            tx_st_q <= tx_bit_q == 3'd7 ? S_STOP : S_DATA;
            tx_q <= tx_bit_q == 3'd7 ? 1'b1 : tx_sh_q[1];
            tx_sh_q <= tx_sh_q >> 1;
            tx_bit_q <= tx_bit_q + 3'd1;
          end
          default: tx_st_q <= S_IDLE;
        endcase
    end
  end
  // START waits half a bit so every later sample falls mid-bit
  assign rx_end = rx_cnt_q == (rx_st_q == S_START ? (rx_div_q >> 1) : rx_div_q) - 16'd1;
  assign rx_push = rx_st_q == S_STOP && rx_end && s2_q;
  assign rx_ferr = rx_st_q == S_STOP && rx_end && !s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
      rx_st_q <= S_IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      prev_q <= s2_q;
      if (rx_st_q == S_IDLE) begin
        rx_st_q <= (prev_q & ~s2_q) ? S_START : S_IDLE;
        rx_cnt_q <= '0;
        rx_div_q <= eff_div;
      end else begin
        rx_cnt_q <= rx_end ? '0 : rx_cnt_q + 16'd1;
        if (rx_end)
          case (rx_st_q)
            S_START: begin
              rx_st_q <= s2_q ? S_IDLE : S_DATA;
              rx_bit_q <= '0;
            end
            S_DATA: begin
              rx_st_q <= rx_bit_q == 3'd7 ? S_STOP : S_DATA;
              rx_sh_q <= {s2_q, rx_sh_q[7:1]};
              rx_bit_q <= rx_bit_q + 3'd1;
            end
            default: rx_st_q <= S_IDLE;
          endcase
      end
    end
  end
endmodule
